// File: rtl/tag_ram_ctrl_if.sv
// Request/response and tag-RAM bus shared by the tag RAM controller and its environment.
// "slave" is the controller's view; "master" is the requesters' and RAM's view.
interface tag_ram_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 9
) ();
  localparam int DWIDTH = TWIDTH + 2;

  logic              cpu_req;
  logic [1:0]        cpu_op;
  logic [AWIDTH-1:0] cpu_idx;
  logic [TWIDTH-1:0] cpu_tag;
  logic [1:0]        cpu_state;
  logic              cpu_ack;

  logic              snp_req;
  logic [1:0]        snp_op;
  logic [AWIDTH-1:0] snp_idx;
  logic [TWIDTH-1:0] snp_tag;
  logic [1:0]        snp_state;
  logic              snp_ack;

  logic              resp_hit;
  logic [1:0]        resp_state;
  logic [TWIDTH-1:0] resp_tag;

  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_op, cpu_idx, cpu_tag, cpu_state,
    input  snp_req, snp_op, snp_idx, snp_tag, snp_state,
    input  ram_dout,
    output cpu_ack, snp_ack, resp_hit, resp_state, resp_tag,
    output ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output cpu_req, cpu_op, cpu_idx, cpu_tag, cpu_state,
    output snp_req, snp_op, snp_idx, snp_tag, snp_state,
    output ram_dout,
    input  cpu_ack, snp_ack, resp_hit, resp_state, resp_tag,
    input  ram_addr, ram_din, ram_we, busy
  );
endinterface

// File: rtl/tag_ram_ctrl.sv
// MSI tag RAM controller: arbitrates CPU and snoop requests round-robin and runs
// LOOKUP / FILL / SETST against a synchronous-read tag RAM. Every output is a register.
module tag_ram_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 9
) (
  input  logic           clock,
  input  logic           reset_n,
  tag_ram_ctrl_if.slave  bus
);
  localparam int DWIDTH = TWIDTH + 2;
  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_SETST  = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, CMP, WB, DONE} state_t;

  state_t            state_reg;
  logic              rr_snp_reg;
  logic              win_snp_reg;
  logic [1:0]        op_reg;
  logic [TWIDTH-1:0] tag_reg;
  logic [1:0]        st_reg;
  logic [AWIDTH-1:0] ram_addr_reg;
  logic [DWIDTH-1:0] ram_din_reg;
  logic              ram_we_reg;
  logic              cpu_ack_reg;
  logic              snp_ack_reg;
  logic              busy_reg;
  logic              resp_hit_reg;
  logic [1:0]        resp_state_reg;
  logic [TWIDTH-1:0] resp_tag_reg;

  logic              any_req;
  logic              pick_snp;
  logic [1:0]        pick_op;
  logic [AWIDTH-1:0] pick_idx;
  logic [TWIDTH-1:0] pick_tag;
  logic [1:0]        pick_st;
  logic [1:0]        ent_st;
  logic [TWIDTH-1:0] ent_tag;
  logic              ent_hit;

  // Request selection and entry decode only feed registers, never outputs.
  always_comb begin
    any_req  = bus.cpu_req | bus.snp_req;
    pick_snp = bus.snp_req & (~bus.cpu_req | rr_snp_reg);
    if (pick_snp) begin
      pick_op  = bus.snp_op;
      pick_idx = bus.snp_idx;
      pick_tag = bus.snp_tag;
      pick_st  = bus.snp_state;
    end else begin
      pick_op  = bus.cpu_op;
      pick_idx = bus.cpu_idx;
      pick_tag = bus.cpu_tag;
      pick_st  = bus.cpu_state;
    end
    ent_st  = bus.ram_dout[DWIDTH-1 -: 2];
    ent_tag = bus.ram_dout[TWIDTH-1:0];
    ent_hit = ((ent_st == 2'b01) || (ent_st == 2'b10)) && (ent_tag == tag_reg);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      rr_snp_reg     <= 1'b1;
      win_snp_reg    <= 1'b0;
      op_reg         <= OP_LOOKUP;
      tag_reg        <= '0;
      st_reg         <= '0;
      ram_addr_reg   <= '0;
      ram_din_reg    <= '0;
      ram_we_reg     <= 1'b0;
      cpu_ack_reg    <= 1'b0;
      snp_ack_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_state_reg <= '0;
      resp_tag_reg   <= '0;
    end else begin
      cpu_ack_reg <= 1'b0;
      snp_ack_reg <= 1'b0;
      ram_we_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            win_snp_reg  <= pick_snp;
            rr_snp_reg   <= ~pick_snp;
            op_reg       <= (pick_op == 2'b11) ? OP_LOOKUP : pick_op;
            tag_reg      <= pick_tag;
            st_reg       <= pick_st;
            ram_addr_reg <= pick_idx;
            busy_reg     <= 1'b1;
            if (pick_op == OP_FILL) begin
              state_reg   <= WB;
              ram_we_reg  <= 1'b1;
              ram_din_reg <= {pick_st, pick_tag};
            end else begin
              state_reg <= RD;
            end
          end
        end
        RD: state_reg <= CMP;
        CMP: begin
          resp_hit_reg   <= ent_hit;
          resp_state_reg <= ent_st;
          resp_tag_reg   <= ent_tag;
          if ((op_reg == OP_SETST) && ent_hit) begin
            state_reg   <= WB;
            ram_we_reg  <= 1'b1;
            ram_din_reg <= {st_reg, ent_tag};
          end else begin
            state_reg    <= DONE;
            ram_addr_reg <= '0;
            cpu_ack_reg  <= ~win_snp_reg;
            snp_ack_reg  <= win_snp_reg;
          end
        end
        WB: begin
          state_reg    <= DONE;
          ram_addr_reg <= '0;
          cpu_ack_reg  <= ~win_snp_reg;
          snp_ack_reg  <= win_snp_reg;
          // A FILL never reads the RAM, so it reports what it wrote.
          if (op_reg == OP_FILL) begin
            resp_hit_reg   <= 1'b0;
            resp_state_reg <= st_reg;
            resp_tag_reg   <= tag_reg;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr   = ram_addr_reg;
  assign bus.ram_din    = ram_din_reg;
  assign bus.ram_we     = ram_we_reg;
  assign bus.cpu_ack    = cpu_ack_reg;
  assign bus.snp_ack    = snp_ack_reg;
  assign bus.busy       = busy_reg;
  assign bus.resp_hit   = resp_hit_reg;
  assign bus.resp_state = resp_state_reg;
  assign bus.resp_tag   = resp_tag_reg;
endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Bench for tag_ram_ctrl: synchronous tag RAM model plus an entry-level reference
// model that predicts latency, writes and responses for each operation.
module tb_tag_ram_ctrl;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic mem_clr = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [10:0] mem     [8];
  logic [10:0] exp_mem [8];

  tag_ram_ctrl_if #(.AWIDTH(3), .TWIDTH(9)) bus ();

  tag_ram_ctrl #(.AWIDTH(3), .TWIDTH(9)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Synchronous-read tag RAM, read-before-write.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 11'd0;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic set_req(input bit snp_side, input logic req, input logic [1:0] op,
                         input logic [2:0] idx, input logic [8:0] tag, input logic [1:0] st);
    if (snp_side) begin
      bus.snp_req = req; bus.snp_op = op; bus.snp_idx = idx; bus.snp_tag = tag; bus.snp_state = st;
    end else begin
      bus.cpu_req = req; bus.cpu_op = op; bus.cpu_idx = idx; bus.cpu_tag = tag; bus.cpu_state = st;
    end
  endtask

  // One operation from one requester, predicted from the entry-level MSI rules.
  task automatic do_op(input bit snp_side, input logic [1:0] op, input logic [2:0] idx,
                       input logic [8:0] tag, input logic [1:0] st, input string nm);
    logic [10:0] entry;
    logic        ehit;
    int          exp_lat;
    int          exp_we;
    logic [10:0] exp_din;
    logic        exp_hit;
    logic [1:0]  exp_st;
    logic [8:0]  exp_tag;
    int          n;
    int          we_cnt;
    logic [10:0] din_seen;
    logic        got;
    logic [31:0] r;

    entry   = exp_mem[idx];
    ehit    = ((entry[10:9] == 2'b01) || (entry[10:9] == 2'b10)) && (entry[8:0] == tag);
    exp_we  = 0;
    exp_din = 11'd0;
    if (op == 2'b01) begin
      exp_lat = 2; exp_we = 1; exp_din = {st, tag};
      exp_hit = 1'b0; exp_st = st; exp_tag = tag;
      exp_mem[idx] = {st, tag};
    end else begin
      exp_lat = 3; exp_hit = ehit; exp_st = entry[10:9]; exp_tag = entry[8:0];
      if (op == 2'b10 && ehit) begin
        exp_lat = 4; exp_we = 1; exp_din = {st, entry[8:0]};
        exp_mem[idx] = {st, entry[8:0]};
      end
    end

    set_req(snp_side, 1'b1, op, idx, tag, st);
    n = 0; we_cnt = 0; din_seen = 11'd0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) begin
        // Payload is already captured; scrambling it must change nothing.
        r = $urandom;
        set_req(snp_side, 1'b1, r[1:0], r[4:2], r[13:5], r[15:14]);
      end
      if (bus.ram_we) begin
        we_cnt++;
        din_seen = bus.ram_din;
      end
      got = snp_side ? bus.snp_ack : bus.cpu_ack;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we != 0) chk({nm, "_din"}, 32'(din_seen), 32'(exp_din));
    chk({nm, "_hit"}, 32'(bus.resp_hit), 32'(exp_hit));
    chk({nm, "_state"}, 32'(bus.resp_state), 32'(exp_st));
    chk({nm, "_tag"}, 32'(bus.resp_tag), 32'(exp_tag));
    chk({nm, "_other_ack"}, 32'(snp_side ? bus.cpu_ack : bus.snp_ack), 32'd0);
    @(posedge clock); #1;
    set_req(snp_side, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);
    chk({nm, "_ack_pulse"}, 32'(snp_side ? bus.snp_ack : bus.cpu_ack), 32'd0);
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
    $display("op %s side=%0d op=%0d idx=%0d tag=%03h st=%0d lat=%0d hit=%0d rstate=%0d rtag=%03h",
             nm, snp_side, op, idx, tag, st, n, bus.resp_hit, bus.resp_state, bus.resp_tag);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);
    set_req(1'b1, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);
    @(posedge clock); @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin : main
    logic [31:0] r;
    logic [8:0]  rtag;
    int          acks;
    int          n;

    for (int i = 0; i < 8; i++) exp_mem[i] = 11'd0;
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);
    set_req(1'b1, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_snp_ack", 32'(bus.snp_ack), 32'd0);
    chk("rst_hit", 32'(bus.resp_hit), 32'd0);
    chk("rst_state", 32'(bus.resp_state), 32'd0);
    chk("rst_tag", 32'(bus.resp_tag), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    $display("reset checked");
    @(negedge clock); reset_n = 1'b1; mem_clr = 1'b0;
    @(posedge clock); #1;

    // Directed MSI scenarios
    do_op(1'b0, 2'b01, 3'd3, 9'h0A5, 2'b10, "fill_a5");
    chk("fill_a5_din_const", 32'(exp_mem[3]), 32'h4A5);
    do_op(1'b0, 2'b00, 3'd3, 9'h0A5, 2'b00, "lookup_hit");
    do_op(1'b0, 2'b00, 3'd3, 9'h0A4, 2'b00, "lookup_miss");
    do_op(1'b1, 2'b10, 3'd3, 9'h0A5, 2'b00, "setst_inval");
    do_op(1'b0, 2'b00, 3'd3, 9'h0A5, 2'b00, "lookup_inval");
    do_op(1'b0, 2'b01, 3'd6, 9'h1F0, 2'b11, "fill_st11");
    do_op(1'b1, 2'b10, 3'd6, 9'h1F0, 2'b01, "setst_st11");
    do_op(1'b0, 2'b11, 3'd6, 9'h1F0, 2'b00, "op11_lookup");

    // Simultaneous requests after reset: snp first, then strict alternation
    pulse_reset();
    set_req(1'b1, 1'b1, 2'b01, 3'd2, 9'h0C3, 2'b10);
    set_req(1'b0, 1'b1, 2'b00, 3'd2, 9'h0C3, 2'b00);
    exp_mem[2] = {2'b10, 9'h0C3};
    acks = 0; n = 0;
    while (acks < 6 && n < 200) begin
      @(posedge clock); #1;
      n++;
      if (bus.snp_ack) begin
        chk("arb_snp_turn", 32'(acks % 2), 32'd0);
        chk("arb_dual_ack", 32'(bus.cpu_ack), 32'd0);
        $display("arb grant %0d snp", acks);
        acks++;
      end else if (bus.cpu_ack) begin
        chk("arb_cpu_turn", 32'(acks % 2), 32'd1);
        chk("arb_cpu_sees_fill", 32'(bus.resp_hit), 32'd1);
        chk("arb_cpu_tag", 32'(bus.resp_tag), 32'h0C3);
        $display("arb grant %0d cpu", acks);
        acks++;
      end
    end
    chk("arb_ack_count", 32'(acks), 32'd6);
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);
    set_req(1'b1, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);

    // Reset while writing back: write dropped, no ack
    set_req(1'b0, 1'b1, 2'b01, 3'd5, 9'h155, 2'b01);
    @(posedge clock); #1;
    chk("wbrst_we_high", 32'(bus.ram_we), 32'd1);
    #2;
    reset_n = 1'b0;
    set_req(1'b0, 1'b0, 2'b00, 3'd0, 9'd0, 2'b00);
    #1;
    chk("wbrst_we_low", 32'(bus.ram_we), 32'd0);
    chk("wbrst_busy", 32'(bus.busy), 32'd0);
    chk("wbrst_addr", 32'(bus.ram_addr), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk("wbrst_no_ack", 32'(bus.cpu_ack), 32'd0);
      chk("wbrst_idle", 32'(bus.busy), 32'd0);
    end
    $display("reset during WB checked");
    do_op(1'b0, 2'b00, 3'd5, 9'h155, 2'b00, "wbrst_lookup");
    do_op(1'b0, 2'b01, 3'd5, 9'h155, 2'b01, "wbrst_refill");
    do_op(1'b1, 2'b10, 3'd5, 9'h155, 2'b10, "wbrst_upgrade");

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      case (r[7:6])
        2'd0:    rtag = 9'h0A5;
        2'd1:    rtag = 9'h0A4;
        2'd2:    rtag = 9'h0C3;
        default: rtag = r[16:8];
      endcase
      do_op(r[0], r[2:1], r[5:3], rtag, r[18:17], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tag_ram_ctrl.md
TAG_RAM_CTRL -- requirements
Module: tag_ram_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 3: tag RAM index width, giving 8 sets.
REQ-002 SHALL have parameter TWIDTH, default 9: tag field width; RAM entry width DWIDTH = TWIDTH+2 = 11.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have per requester p in {cpu, snp} (CPU side, bus snoop side) the inputs p_req (1), p_op (2), p_idx (AWIDTH), p_tag (TWIDTH) and p_state (2).
REQ-006 SHALL have per requester p the output p_ack (1): one-cycle completion pulse.
REQ-007 SHALL have outputs resp_hit (1), resp_state (2) and resp_tag (TWIDTH): the shared response bus.
REQ-008 SHALL have outputs ram_addr (AWIDTH), ram_din (DWIDTH) and ram_we (1), plus input ram_dout (DWIDTH), to drive a synchronous-read tag RAM.
REQ-009 SHALL have output busy (1): high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL use entry format [10:9] = MSI state (00 I, 01 S, 10 M, 11 treated as I) and [8:0] = tag.
REQ-011 SHALL support ops: 00 LOOKUP, 01 FILL (unconditional write of {p_state,p_tag}), 10 SETST (on hit, rewrite the state with p_state and keep the tag); op 11 SHALL execute as LOOKUP.
REQ-012 SHALL implement hit = (entry state is 01 or 10) AND (entry tag == request tag).
REQ-013 SHALL implement FSM states IDLE, RD, CMP, WB, DONE.
REQ-014 Transitions: IDLE -> RD on any req for LOOKUP or SETST; IDLE -> WB for FILL; RD -> CMP; CMP -> WB if SETST and hit, else DONE; WB -> DONE; DONE -> IDLE.
REQ-015 SHALL capture op, idx, tag, state and winner ID into internal registers at the accepting edge; later changes on request inputs SHALL have no effect.
REQ-016 SHALL drive ram_addr = captured idx in RD, CMP and WB, and 0 otherwise.
REQ-017 SHALL assert ram_we only in WB.
REQ-018 SHALL drive ram_din = {p_state, p_tag} for FILL and {p_state, ram tag registered in CMP} for SETST.
REQ-019 SHALL sample ram_dout only in CMP, where it reflects the address latched at the RD->CMP edge.
REQ-020 SHALL register resp_hit, resp_state and resp_tag at the CMP exit edge and hold them until the next CMP exit.
REQ-021 For FILL, SHALL set resp_hit = 0, resp_state = written state and resp_tag = written tag at the WB exit edge.
REQ-022 Arbitration: a single requester SHALL win; when both request in IDLE, a round-robin pointer SHALL decide, initially favouring snp and toggling to the other side after every grant.
REQ-023 Latency, accept edge to ack: LOOKUP and SETST-miss SHALL ack 3 cycles after accept; SETST-hit SHALL ack 4 cycles after; FILL SHALL ack 2 cycles after.
REQ-024 p_ack SHALL be high only in DONE and only for the winner; the requester SHALL hold p_req and its payload stable until ack and SHALL drop or renew p_req in the cycle after ack.
REQ-025 The loser SHALL stay pending without loss; two ops to the same index SHALL serialize strictly in grant order, with the second op observing the first op's write.
REQ-026 All outputs SHALL come from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-027 On reset_n low, the FSM SHALL go immediately to IDLE and ram_we, cpu_ack, snp_ack, busy, resp_hit, resp_state, resp_tag and ram_addr SHALL all go to 0; the RR pointer SHALL be set to favour snp.
REQ-028 Reset in WB SHALL deassert ram_we asynchronously; the op is dropped, no ack is issued, and the RAM content is whatever the RAM held at the last completed edge.

Verification
REQ-029 cpu FILL idx=3 tag=0x0A5 state=10 -> ram_we high exactly 1 cycle with ram_din=0x4A5; cpu_ack 2 cycles after accept.
REQ-030 cpu LOOKUP idx=3 tag=0x0A5 after REQ-029 -> cpu_ack 3 cycles after accept with resp_hit=1, resp_state=10; LOOKUP tag=0x0A4 -> resp_hit=0, resp_tag=0x0A5.
REQ-031 snp SETST idx=3 tag=0x0A5 state=00 -> ram_we once with ram_din=0x0A5; snp_ack 4 cycles after accept; a following LOOKUP -> resp_hit=0.
REQ-032 cpu and snp both request in the same cycle after reset -> snp served first, cpu next; with both held continuously, grants alternate and neither side starves.
REQ-033 reset_n pulsed low during WB -> ram_we falls in the same cycle with no ack; after release, busy=0 and the next request completes normally.
REQ-034 SETST to an entry with state 11 -> treated as a miss, no write, resp_hit=0, ack 3 cycles after accept.
